// File: rtl/jacobian_pkg.sv
// jacobian_pkg: shared fixed-point types, pipeline stage records and FSM states for jacobian_column
package jacobian_pkg;
  localparam int FRAC_BITS_DEF = 16;
  typedef logic signed [31:0] fx_t;
  typedef fx_t [2:0] vec3_t;
  typedef logic signed [32:0] dx_t;
  typedef logic signed [64:0] prod_t;
  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;
  typedef struct packed {
    logic v;
    logic [2:0] idx;
    logic last;
    vec3_t z;
    dx_t [2:0] d;
  } s1_t;
  typedef struct packed {
    logic v;
    logic [2:0] idx;
    logic last;
    vec3_t z;
    prod_t [5:0] p;
  } s2_t;
  typedef struct packed {
    logic v;
    logic [2:0] idx;
    logic last;
    vec3_t jw;
    vec3_t jv;
  } out_t;
endpackage

// File: rtl/jacobian_column_cross3_sat.sv
// cross3_sat: pairwise product differences, fixed-point rescale and signed 32-bit saturation
module cross3_sat import jacobian_pkg::*; #(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  prod_t [5:0] p,
  output vec3_t       r
);
  function automatic fx_t sat(input prod_t a, input prod_t b);
    logic signed [65:0] s;
    s = (66'(a) - 66'(b)) >>> FRAC_BITS;
    return s > 66'sh0_7FFF_FFFF ? 32'sh7FFF_FFFF : s < -66'sh0_8000_0000 ? 32'sh8000_0000 : s[31:0];
  endfunction
  assign r = {sat(p[4], p[5]), sat(p[2], p[3]), sat(p[0], p[1])};
endmodule

// File: rtl/jacobian_column.sv
// jacobian_column: buffers joint frames, then streams z x (p_e - p) columns through a 3-stage pipeline
module jacobian_column import jacobian_pkg::*; #(
  parameter int N_JOINTS  = 6,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  vec3_t      in_z,
  input  vec3_t      in_p,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output vec3_t      out_jv,
  output vec3_t      out_jw,
  output logic [2:0] out_idx,
  output logic       out_last,
  output logic       err
);
  localparam int CW = $clog2(N_JOINTS + 1);
  localparam int IW = N_JOINTS > 1 ? $clog2(N_JOINTS) : 1;
  state_t state_q, state_d;
  logic run_q, err_q, err_d, stall, hs;
  logic [CW-1:0] count_q, count_d, iss_q, iss_d;
  vec3_t pe_q, pe_d, jv;
  vec3_t bz_q [N_JOINTS];
  vec3_t bz_d [N_JOINTS];
  vec3_t bp_q [N_JOINTS];
  vec3_t bp_d [N_JOINTS];
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  out_t o_q, o_d;
  cross3_sat #(.FRAC_BITS(FRAC_BITS)) u_cross (.p(s2_q.p), .r(jv));
  assign stall = o_q.v && !out_ready;
  assign in_ready = run_q && state_q == LOAD;
  assign hs = in_ready && in_valid;
  assign out_valid = o_q.v;
  assign out_jv = o_q.jv;
  assign out_jw = o_q.jw;
  assign out_idx = o_q.idx;
  assign out_last = o_q.last;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    iss_d = iss_q;
    err_d = err_q;
    pe_d = pe_q;
    bz_d = bz_q;
    bp_d = bp_q;
    if (hs && in_last) begin
      err_d = err_q || count_q == '0;
      state_d = count_q == '0 ? LOAD : COMPUTE;
      pe_d = in_p;
      iss_d = '0;
    end else if (hs) begin
      if (count_q == CW'(N_JOINTS)) begin
        err_d = 1'b1;
      end else begin
        bz_d[IW'(count_q)] = in_z;
        bp_d[IW'(count_q)] = in_p;
        count_d = count_q + CW'(1);
      end
    end
    if (state_q == COMPUTE && !stall) begin
      iss_d = iss_q + CW'(1);
      state_d = iss_q == count_q - CW'(1) ? DRAIN : COMPUTE;
    end
    if (state_q == DRAIN && o_q.v && out_ready && o_q.last) begin
      state_d = LOAD;
      count_d = '0;
    end
  end
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    o_d = o_q;
    if (!stall) begin
      s1_d.v = state_q == COMPUTE;
      s1_d.idx = 3'(iss_q);
      s1_d.last = iss_q == count_q - CW'(1);
      s1_d.z = bz_q[IW'(iss_q)];
      for (int k = 0; k < 3; k++) s1_d.d[k] = dx_t'($signed(pe_q[k])) - dx_t'($signed(bp_q[IW'(iss_q)][k]));
      s2_d.v = s1_q.v;
      s2_d.idx = s1_q.idx;
      s2_d.last = s1_q.last;
      s2_d.z = s1_q.z;
      s2_d.p[0] = prod_t'($signed(s1_q.z[1])) * prod_t'($signed(s1_q.d[2]));
      s2_d.p[1] = prod_t'($signed(s1_q.z[2])) * prod_t'($signed(s1_q.d[1]));
      s2_d.p[2] = prod_t'($signed(s1_q.z[2])) * prod_t'($signed(s1_q.d[0]));
      s2_d.p[3] = prod_t'($signed(s1_q.z[0])) * prod_t'($signed(s1_q.d[2]));
      s2_d.p[4] = prod_t'($signed(s1_q.z[0])) * prod_t'($signed(s1_q.d[1]));
      s2_d.p[5] = prod_t'($signed(s1_q.z[1])) * prod_t'($signed(s1_q.d[0]));
      o_d = '{v: s2_q.v, idx: s2_q.idx, last: s2_q.last, jw: s2_q.z, jv: jv};
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      run_q <= 1'b0;
      count_q <= '0;
      iss_q <= '0;
      err_q <= 1'b0;
      pe_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      o_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= 1'b1;
      count_q <= count_d;
      iss_q <= iss_d;
      err_q <= err_d;
      pe_q <= pe_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      o_q <= o_d;
    end
  end
  always_ff @(posedge clk) begin
    bz_q <= bz_d;
    bp_q <= bp_d;
  end
endmodule

// File: doc/jacobian_column.md
JACOBIAN_COLUMN -- requirements
Module: jacobian_column

Interface
REQ-001 Parameter N_JOINTS, default 6: maximum joint frames buffered per chain.
REQ-002 Parameter FRAC_BITS, default 16: fractional bits of all signed 32-bit fixed-point data (1.0 = 0x0001_0000).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  frame from the upstream transform stage is valid.
REQ-006 in_ready  out  1  block accepts a frame this cycle.
REQ-007 in_z  in  3x32  z-axis (third rotation column) of the cumulative transform.
REQ-008 in_p  in  3x32  origin (fourth column) of the cumulative transform.
REQ-009 in_last  in  1  frame is the end-effector frame; only in_p is used, as p_e.
REQ-010 out_valid  out  1  Jacobian column valid.
REQ-011 out_ready  in  1  downstream accepts a column.
REQ-012 out_jv  out  3x32  linear part, z_i x (p_e - p_i).
REQ-013 out_jw  out  3x32  angular part, z_i.
REQ-014 out_idx  out  3  joint index of the column, 0-based.
REQ-015 out_last  out  1  column is the last of the chain.
REQ-016 err  out  1  sticky: joint overflow or empty chain; cleared by reset only.

Function
REQ-017 FSM states: LOAD, COMPUTE, DRAIN.
- LOAD: in_ready=1; each non-last handshake stores (z,p) in buffer[count]; count increments.
- Handshake with in_last in LOAD latches p_e, then -> COMPUTE.
REQ-018 A non-last frame arriving with count==N_JOINTS SHALL be accepted and dropped, setting err.
REQ-019 in_last with count==0 SHALL set err and stay in LOAD; no column is produced.
REQ-020 in_ready SHALL be 0 in COMPUTE and DRAIN.
REQ-021 COMPUTE issues joints 0..count-1 in order, one per cycle; a three-stage pipeline stalls globally while out_valid && !out_ready.
- S1: d = p_e - p_i, 33-bit.
- S2: six signed products z*d, full width.
- S3: pairwise differences (x = zy*dz - zz*dy, y = zz*dx - zx*dz, z = zx*dy - zy*dx), arithmetic shift right by FRAC_BITS, saturate to signed 32-bit.
REQ-022 Unstalled latency from issue to out_valid SHALL be 3 cycles; throughput one column per cycle.
REQ-023 out_jw, out_idx and out_last SHALL travel in the pipeline with their column.
REQ-024 out_last SHALL be 1 only for index count-1.
REQ-025 After the last issue the FSM SHALL enter DRAIN, then return to LOAD with count=0 on the cycle after the out_last handshake.
REQ-026 Output payload SHALL remain stable while out_valid && !out_ready.

Reset
REQ-027 While rst==0, all of the following SHALL hold:
- state = LOAD; count = 0.
- in_ready = 0; out_valid = 0.
- out_jv, out_jw = 0; out_idx = 0; out_last = 0; err = 0.
- Pipeline valid bits cleared.
REQ-028 Assertion mid-chain SHALL discard all buffered frames and in-flight columns.
REQ-029 in_ready SHALL rise on the first clock edge after rst deasserts.

Structure
REQ-030 Shared package jacobian_pkg holds:
- fixed-point typedef fx_t (signed 32-bit) and vec3_t (3 x fx_t);
- FRAC_BITS default;
- FSM state enum.
REQ-031 Cross product and saturation SHALL be one sub-module, cross3_sat, instantiated once inside the pipeline.
REQ-032 The frame buffer SHALL be registers, not a RAM macro.

Verification
REQ-033 One joint z=(0,0,1.0) p=(0,0,0), end effector p_e=(1.0,0,0) -> one column: jv=(0,1.0,0), jw=(0,0,1.0), idx=0, last=1, latency 3 cycles after issue.
REQ-034 Three joints, all z=(0,0,1.0), p=(0,0,0),(1.0,0,0),(2.0,0,0), p_e=(3.0,0,0), out_ready=1 -> jv_y = 3.0, 2.0, 1.0 on consecutive cycles; last only on idx 2.
REQ-035 Same stream, out_ready low for 4 cycles after first out_valid -> payload held, no loss or duplication, same values as REQ-034.
REQ-036 Seven non-last frames then in_last -> err=1; six columns produced.
REQ-037 in_last with no prior joints -> err=1, no out_valid, FSM remains in LOAD.
REQ-038 Overflow and reset:
- z=(0,0,0x7FFF_FFFF), d_x=0x7FFF_FFFF -> jv_y saturates to 0x7FFF_FFFF.
- rst=0 mid-COMPUTE -> all outputs zero immediately.
- Next chain after reset produces correct results.
